pitch_freq_calc: RTL

PITCH_FREQ_CALC -- requirements
Module: pitch_freq_calc

---
 rtl/pitch_pkg.sv | 25 ++
 rtl/seq_divider.sv | 75 +++++++
 rtl/pitch_freq_calc.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pitch_pkg.sv
// Shared defaults and types for the pitch-detection pipeline (lag search and frequency stage).
package pitch_pkg;

  localparam int unsigned FS_DEFAULT         = 2000;
  localparam int unsigned MAX_TAU_DEFAULT    = 40;
  localparam int unsigned MIN_TAU_DEFAULT    = 2;
  localparam int unsigned TAU_WIDTH_DEFAULT  = 8;
  localparam int unsigned FRAC_BITS_DEFAULT  = 4;
  localparam int unsigned FREQ_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DIVIDE,
    ST_DONE
  } pitch_state_t;

  // True when a lag lies inside the detectable pitch band.
  function automatic logic tau_in_range(input int unsigned tau,
                                        input int unsigned lo,
                                        input int unsigned hi);
    return (tau >= lo) && (tau <= hi);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle MSB first; the start cycle already
// resolves the first bit so WIDTH bits finish in WIDTH cycles and done pulses the cycle after.
module seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             active_q;
  logic             done_q;

  logic [WIDTH-1:0] step_rem_c;
  logic [WIDTH-1:0] step_quo_c;
  logic [WIDTH:0]   trial_c;
  logic [WIDTH-1:0] next_rem_c;
  logic [WIDTH-1:0] next_quo_c;

  // One restoring step, fed from the operands on start or from the running state otherwise.
  always_comb begin
    step_rem_c = start ? '0 : rem_q;
    step_quo_c = start ? dividend : quo_q;
    trial_c    = {step_rem_c, step_quo_c[WIDTH-1]};
    next_rem_c = trial_c[WIDTH-1:0];
    next_quo_c = {step_quo_c[WIDTH-2:0], 1'b0};
    if (trial_c >= {1'b0, divisor}) begin
      next_rem_c = WIDTH'(trial_c - {1'b0, divisor});
      next_quo_c = {step_quo_c[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q    <= next_rem_c;
        quo_q    <= next_quo_c;
        cnt_q    <= CNT_W'(WIDTH - 1);
        active_q <= 1'b1;
      end else if (active_q) begin
        rem_q <= next_rem_c;
        quo_q <= next_quo_c;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = done_q;
  assign busy      = active_q;

endmodule

// File: rtl/pitch_freq_calc.sv
// Converts a detected lag (samples) into a fixed-point pitch in Hz: (FS << FRAC_BITS) / tau,
// with range check, rising-edge start detection and a sequential divider.
module pitch_freq_calc
  import pitch_pkg::*;
#(
  parameter int unsigned FS         = FS_DEFAULT,
  parameter int unsigned MAX_TAU    = MAX_TAU_DEFAULT,
  parameter int unsigned MIN_TAU    = MIN_TAU_DEFAULT,
  parameter int unsigned TAU_WIDTH  = TAU_WIDTH_DEFAULT,
  parameter int unsigned FRAC_BITS  = FRAC_BITS_DEFAULT,
  parameter int unsigned FREQ_WIDTH = FREQ_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tau_ready,
  input  logic [TAU_WIDTH-1:0]  min_tau,
  output logic [FREQ_WIDTH-1:0] freq,
  output logic                  freq_valid,
  output logic                  no_pitch,
  output logic                  busy
);

  localparam longint unsigned DIVIDEND_FULL = 64'(FS) << FRAC_BITS;
  localparam logic [FREQ_WIDTH-1:0] DIVIDEND = FREQ_WIDTH'(DIVIDEND_FULL);

  // The scaled sample rate must fit the quotient width or the result silently wraps.
  generate
    if (DIVIDEND_FULL >= (64'd1 << FREQ_WIDTH)) begin : g_freq_width_check
      $error("pitch_freq_calc: FS << FRAC_BITS does not fit in FREQ_WIDTH bits");
    end
  endgenerate

  pitch_state_t          state, next_state;
  logic                  tau_ready_q;
  logic [TAU_WIDTH-1:0]  tau_q, tau_d;
  logic [FREQ_WIDTH-1:0] freq_d;
  logic                  no_pitch_d;
  logic                  freq_valid_d;
  logic                  busy_d;
  logic                  start_evt_c;
  logic                  div_start_c;
  logic                  div_done;
  logic                  div_busy;
  logic [FREQ_WIDTH-1:0] div_quotient;
  logic [FREQ_WIDTH-1:0] div_remainder;

  assign start_evt_c = tau_ready & ~tau_ready_q;

  seq_divider #(
    .WIDTH(FREQ_WIDTH)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start_c),
    .dividend (DIVIDEND),
    .divisor  (FREQ_WIDTH'(tau_q)),
    .quotient (div_quotient),
    .remainder(div_remainder),
    .done     (div_done),
    .busy     (div_busy)
  );

  // Edge register resets high so a level already present at reset release is not a start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      tau_ready_q <= 1'b1;
      tau_q       <= '0;
      freq        <= '0;
      no_pitch    <= 1'b0;
      freq_valid  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= next_state;
      tau_ready_q <= tau_ready;
      tau_q       <= tau_d;
      freq        <= freq_d;
      no_pitch    <= no_pitch_d;
      freq_valid  <= freq_valid_d;
      busy        <= busy_d;
    end
  end

  always_comb begin
    next_state   = state;
    tau_d        = tau_q;
    freq_d       = freq;
    no_pitch_d   = no_pitch;
    freq_valid_d = 1'b0;
    div_start_c  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_evt_c) begin
          tau_d      = min_tau;
          next_state = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!tau_in_range(32'(tau_q), MIN_TAU, MAX_TAU)) begin
          no_pitch_d = 1'b1;
          freq_d     = '0;
          next_state = ST_DONE;
        end else begin
          no_pitch_d  = 1'b0;
          div_start_c = 1'b1;
          next_state  = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        if (div_done) next_state = ST_DONE;
      end
      ST_DONE: begin
        if (!no_pitch) freq_d = div_quotient;
        freq_valid_d = 1'b1;
        next_state   = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
    busy_d = (next_state != ST_IDLE);
  end

endmodule
